// File: rtl/alu_result_stage.sv
// Result/flag stage behind alu_adder: a 2-entry result FIFO with NZCV tagging,
// the architectural flag register, sticky V/C bits and a saturating overflow counter.
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_ovf,
  input  logic             in_carry,
  input  logic             in_flag_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_nzcv,
  output logic [3:0]       flags_nzcv,
  output logic             sticky_v,
  output logic             sticky_c,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] data_q [2];
  logic [WIDTH-1:0] data_d [2];
  logic [3:0]       nzcv_q [2];
  logic [3:0]       nzcv_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic [3:0]       flags_q, flags_d;
  logic             sticky_v_q, sticky_v_d;
  logic             sticky_c_q, sticky_c_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic       accept;
  logic       pop;
  logic [3:0] nzcv_in;

  assign accept  = in_valid & in_ready_q;
  assign pop     = out_valid & out_ready;
  assign nzcv_in = {in_sum[WIDTH-1], (in_sum == '0), in_carry, in_ovf};

  // in_ready is a flop fed from the next-state count, so out_ready never reaches it combinationally
  always_comb begin
    data_d     = data_q;
    nzcv_d     = nzcv_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    flags_d    = flags_q;
    sticky_v_d = sticky_v_q;
    sticky_c_d = sticky_c_q;
    ovf_cnt_d  = ovf_cnt_q;

    if (accept) begin
      data_d[wr_ptr_q] = in_sum;
      nzcv_d[wr_ptr_q] = nzcv_in;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != 2'd2);

    if (accept && in_flag_en) begin
      flags_d = nzcv_in;
    end

    // Clear first, then let a same-cycle set override it
    if (sticky_clr) begin
      sticky_v_d = 1'b0;
      sticky_c_d = 1'b0;
    end
    if (accept && in_ovf) begin
      sticky_v_d = 1'b1;
    end
    if (accept && in_carry) begin
      sticky_c_d = 1'b1;
    end

    if (sticky_clr) begin
      ovf_cnt_d = (accept && in_ovf) ? CNT_ONE : '0;
    end else if (accept && in_ovf && (ovf_cnt_q != CNT_MAX)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        nzcv_q[i] <= '0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
      flags_q    <= 4'd0;
      sticky_v_q <= 1'b0;
      sticky_c_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      data_q     <= data_d;
      nzcv_q     <= nzcv_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      flags_q    <= flags_d;
      sticky_v_q <= sticky_v_d;
      sticky_c_q <= sticky_c_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (count_q != 2'd0);
  assign out_result = data_q[rd_ptr_q];
  assign out_nzcv   = nzcv_q[rd_ptr_q];
  assign flags_nzcv = flags_q;
  assign sticky_v   = sticky_v_q;
  assign sticky_c   = sticky_c_q;
  assign ovf_count  = ovf_cnt_q;

endmodule
